mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 14 +
 rtl/mem_access_stage_fsm.sv | 73 +++++++
 rtl/mem_access_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: data/register
// widths and the access FSM state encoding.
package mem_access_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_fsm.sv
// Data-memory handshake FSM with ack-timeout counter; drives request and
// stall, and owns the sticky error flag.
//
// state     | meaning
// ST_IDLE   | no request outstanding; a pending memory op stalls for one cycle
// ST_ACCESS | request asserted, waiting for dmem_ack
// ST_ERROR  | ack timed out; stalls forever, left only through reset
module mem_access_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_op,
  input  logic ack,
  output logic access,
  output logic stall,
  output logic err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == ST_ERROR) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = mem_op;
        if (mem_op) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = '0;
        end
      end
      ST_ACCESS: begin
        access = 1'b1;
        if (ack) begin
          state_nxt = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
          // cnt counts completed ack-less cycles, so this is the last allowed one
          if (cnt == CNT_LAST) state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: stall = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: M and M/W pipeline registers around the data-memory
// handshake FSM. Optional macro MEM_ALIGN_CHECK_EN enables misaligned-op trapping.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] ALUOutE,
  input  logic [WORD_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  output logic [WORD_W-1:0] ALUOutM,
  output logic [REG_W-1:0]  WriteRegM,
  output logic              RegWriteM,
  output logic              MemStall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [WORD_W-1:0] ReadDataW,
  output logic [WORD_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              MemErr
);

  logic [WORD_W-1:0] WriteDataM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic              mem_op_m;
  logic              misalign;
  logic              req_op;
  logic              access;
  logic              err_sticky;
  logic [WORD_W-1:0] addr_req;

  assign mem_op_m = MemtoRegM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op_m & (|ALUOutM[1:0]);
  assign addr_req = ALUOutM;
`else
  assign misalign = 1'b0;
  assign addr_req = {ALUOutM[WORD_W-1:2], 2'b00};
`endif

  // A misaligned op never reaches the FSM, so it neither requests nor stalls.
  assign req_op = mem_op_m & ~misalign;

  mem_access_fsm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .mem_op(req_op),
    .ack   (dmem_ack),
    .access(access),
    .stall (MemStall),
    .err   (err_sticky)
  );

  assign dmem_req   = access;
  assign dmem_we    = access & MemWriteM;
  assign dmem_addr  = access ? addr_req : '0;
  assign dmem_wdata = access ? WriteDataM : '0;
  assign MemErr     = err_sticky | misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else if (!MemStall) begin
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else if (!MemStall) begin
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      RegWriteW <= RegWriteM & ~misalign;
      MemtoRegW <= MemtoRegM & ~misalign;
      if (MemtoRegM & ~misalign) ReadDataW <= dmem_rdata;
    end else begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end
  end

endmodule
